serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial WIDTH-bit subtractor (diff = a - b), the inverse operation of the full_adder.
//   One full-subtractor cell plus a borrow flip-flop processes one bit per clock, LSB first.
//   Start/done handshake; sits beside full_adder in Combinational_Circuits as the sequential sibling.
// PARAMETERS
//   WIDTH   8   operand/result width in bits (legal range 1..32)
// PORTS
//   clk_in      in   1      clock, rising-edge active
//   rst_in      in   1      asynchronous active-high reset
//   start_in    in   1      request; sampled only in IDLE
//   a_in        in   WIDTH  minuend, captured on accepted start
//   b_in        in   WIDTH  subtrahend, captured on accepted start
//   busy_out    out  1      high while in SHIFT
//   done_out    out  1      one-cycle pulse, result valid
//   diff_out    out  WIDTH  a - b mod 2^WIDTH, held until next done
//   borrow_out  out  1      final borrow (1 when a < b unsigned)
//   zero_out    out  1      diff_out == 0
// BEHAVIOUR
//   Reset (async, rst_in=1): state=IDLE; busy_out, done_out, diff_out, borrow_out = 0;
//     zero_out = 1. Internal shift regs, borrow FF and bit counter cleared.
//   FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: start_in=1 at edge E: latch a_in/b_in into shift regs, borrow FF=0, count=0, go SHIFT.
//   SHIFT: each edge: with a0,b0 = LSBs of shift regs, bw = borrow FF:
//     d = a0 ^ b0 ^ bw; bw_next = (~a0 & b0) | (~(a0 ^ b0) & bw);
//     d shifts into MSB of internal result reg; operand regs shift right; count++.
//     After WIDTH bits (edge E+WIDTH) go DONE; diff_out <= result, borrow_out <= bw_next.
//   DONE: done_out=1 for exactly this cycle; next edge -> IDLE unconditionally.
//   Latency: start accepted at edge E -> done_out high in cycle after edge E+WIDTH;
//     next start accepted no earlier than edge E+WIDTH+2 (one IDLE cycle mandatory).
//   busy_out = (state==SHIFT). start_in outside IDLE is ignored, not queued.
//   a_in/b_in changes after capture have no effect on the running operation.
//   diff_out/borrow_out/zero_out change only on the DONE-entry edge; stable otherwise.
//   zero_out is registered from the same value loaded into diff_out.
//   Reset mid-operation: abort immediately, no done_out pulse, outputs to reset values.
//   WIDTH=1: single SHIFT cycle; behaves as registered full subtractor with bw_in=0.
// TESTING
//   WIDTH=8, a=0x5A, b=0x3C, start at E -> done_out at cycle E+9, diff=0x1E, borrow=0, zero=0.
//   a=0x00, b=0x01 -> diff=0xFF, borrow=1; a=0xFF, b=0x00 -> diff=0xFF, borrow=0.
//   a=0x80, b=0x80 -> diff=0x00, borrow=0, zero=1; busy_out high exactly 8 cycles.
//   start held high + a_in/b_in changed during SHIFT -> no restart, result from first operands,
//     next op begins only after one IDLE cycle.
//   rst_in pulsed at SHIFT bit 4 -> no done_out, all outputs reset values; new op afterwards correct.
//   WIDTH=1, all 4 (a,b) combos -> (diff,borrow) = (0,0),(1,1),(1,0),(0,0); random 8-bit vs a-b model.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, with a start/done handshake and results held until the next done.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             zero_out
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, res, res_next;
  logic [CW-1:0]    cnt;
  logic             bw, a0, b0, d, bw_next;

  // Next result includes the bit produced this cycle, so the DONE-entry edge
  // can load diff_out directly without an extra pipeline stage.
  always_comb begin
    a0       = a_sr[0];
    b0       = b_sr[0];
    d        = a0 ^ b0 ^ bw;
    bw_next  = (~a0 & b0) | (~(a0 ^ b0) & bw);
    res_next = res >> 1;
    res_next[WIDTH-1] = d;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res        <= '0;
      bw         <= 1'b0;
      cnt        <= '0;
      busy_out   <= 1'b0;
      done_out   <= 1'b0;
      diff_out   <= '0;
      borrow_out <= 1'b0;
      zero_out   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done_out <= 1'b0;
          if (start_in) begin
            a_sr     <= a_in;
            b_sr     <= b_in;
            res      <= '0;
            bw       <= 1'b0;
            cnt      <= '0;
            busy_out <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          res  <= res_next;
          bw   <= bw_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state      <= DONE;
            busy_out   <= 1'b0;
            done_out   <= 1'b1;
            diff_out   <= res_next;
            borrow_out <= bw_next;
            zero_out   <= (res_next == '0);
          end
        end
        DONE: begin
          // Unconditional return guarantees one IDLE cycle between operations.
          done_out <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          done_out <= 1'b0;
          busy_out <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule
